// File: rtl/clk_step_ctrl_pkg.sv
// Shared types and constants for the run/step/speed clock controller.
// State encodings are fixed so the unused code 2'd3 has a defined recovery path.
package clk_step_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 32;

  // Single-cycle press events from the three debounced buttons.
  typedef struct packed {
    logic run;
    logic step;
    logic speed;
  } btn_evt_t;

  // Snapshot of the control FSM for checkers bound to the top.
  typedef struct packed {
    state_e state;
    logic   div_edge;
    logic   cpu_en;
  } ctrl_dbg_t;

  function automatic logic is_run(input state_e s);
    return s == RUN;
  endfunction

  function automatic logic is_halted(input state_e s);
    return s == HALTED;
  endfunction

endpackage

// File: rtl/clk_step_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and press pulse.
// A press fires DEBOUNCE_CYCLES+3 cycles after the raw level is first sampled high.
module btn_debounce
  import clk_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            meta_q,   meta_d;
  logic            sync_q,   sync_d;
  logic            stable_q, stable_d;
  logic            prev_q,   prev_d;
  logic            press_q,  press_d;
  logic [DB_W-1:0] cnt_q,    cnt_d;

  always_comb begin
    meta_d   = btn_raw;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // Any agreement with the accepted level restarts the stability window.
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/pause/single-step/halt controller turning divided-clock edges into CPU enables.
// Also owns the debounced speed toggle that selects the divider rate.
module clk_step_ctrl
  import clk_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_speed,
  input  logic             div_clk,
  input  logic             halt,
  output logic             changef,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);

  btn_evt_t   evt;
  ctrl_dbg_t  dbg;

  state_e     state_q, state_d;
  logic       cpu_en_q, cpu_en_d;
  logic       running_q, running_d;
  logic       halted_q, halted_d;
  logic       changef_q, changef_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

  logic       div_meta_q, div_meta_d;
  logic       div_sync_q, div_sync_d;
  logic       div_prev_q, div_prev_d;
  logic       div_edge_q, div_edge_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk     (clk_in),
    .rst     (rst),
    .btn_raw (btn_run),
    .press   (evt.run)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk     (clk_in),
    .rst     (rst),
    .btn_raw (btn_step),
    .press   (evt.step)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk     (clk_in),
    .rst     (rst),
    .btn_raw (btn_speed),
    .press   (evt.speed)
  );

  // Divided clock: synchronize, then register the rising-edge detect.
  always_comb begin
    div_meta_d = div_clk;
    div_sync_d = div_meta_q;
    div_prev_d = div_sync_q;
    div_edge_d = div_sync_q & ~div_prev_q;
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt beats run press; HALTED only leaves through reset.
  always_comb begin
    state_d = PAUSE;
    case (state_q)
      PAUSE: begin
        if (halt)         state_d = HALTED;
        else if (evt.run) state_d = RUN;
        else              state_d = PAUSE;
      end
      RUN: begin
        if (halt)         state_d = HALTED;
        else if (evt.run) state_d = PAUSE;
        else              state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = PAUSE;
    endcase
  end

  // cpu_en protocol: a single-cycle strobe with no back-pressure; each high
  // cycle is exactly one CPU step and is never queued or repeated.
  always_comb begin
    cpu_en_d = 1'b0;
    case (state_q)
      PAUSE:   cpu_en_d = ~halt & ~evt.run & evt.step;
      RUN:     cpu_en_d = ~halt & ~evt.run & div_edge_q;
      default: cpu_en_d = 1'b0;
    endcase
    running_d  = is_run(state_d);
    halted_d   = is_halted(state_d);
    step_cnt_d = step_cnt_q + CNT_W'(cpu_en_d);
    changef_d  = changef_q ^ evt.speed;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cpu_en_q   <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      changef_q  <= 1'b0;
      step_cnt_q <= '0;
      div_meta_q <= 1'b0;
      div_sync_q <= 1'b0;
      div_prev_q <= 1'b0;
      div_edge_q <= 1'b0;
    end else begin
      cpu_en_q   <= cpu_en_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      changef_q  <= changef_d;
      step_cnt_q <= step_cnt_d;
      div_meta_q <= div_meta_d;
      div_sync_q <= div_sync_d;
      div_prev_q <= div_prev_d;
      div_edge_q <= div_edge_d;
    end
  end

  assign dbg.state    = state_q;
  assign dbg.div_edge = div_edge_q;
  assign dbg.cpu_en   = cpu_en_q;

  assign changef  = changef_q;
  assign cpu_en   = cpu_en_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign step_cnt = step_cnt_q;

endmodule
